// File: rtl/gpio_debounce_pkg.sv
// Shared types, limits and config check for the GPIO input debounce block.
package gpio_debounce_pkg;

  typedef enum logic {
    StStable,
    StCount
  } deb_state_e;

  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_MIN = 1;

  // The counter must hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic bit debounce_cfg_ok(int unsigned cycles, int unsigned width);
    if (width >= 32) return 1'b1;
    return cycles < (32'd1 << width);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// N-stage reset-valued synchronizer; the first stage picks d_i or alt_i via sel_i.
module gpio_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sel_i,
  input  logic d_i,
  input  logic alt_i,
  output logic q_o
);

  logic [Stages-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {Stages{ResetVal}};
    end else begin
      chain_q <= {chain_q[Stages-2:0], sel_i ? d_i : alt_i};
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: synchronizer, debounce FSM, registered edge pulses.
// Define GPIO_DEBOUNCE_STICKY_EN to add EVT_CLR / EVT_RISE / EVT_FALL sticky flags.
module gpio_in_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic CK,
  input  logic RST,
  input  logic EN,
  input  logic DIN,
`ifdef GPIO_DEBOUNCE_STICKY_EN
  input  logic EVT_CLR,
  output logic EVT_RISE,
  output logic EVT_FALL,
`endif
  output logic DOUT,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN ||
      !debounce_cfg_ok(DEBOUNCE_CYCLES, CNT_WIDTH)) begin : g_bad_cfg
    $error("gpio_in_debounce: illegal SYNC_STAGES/DEBOUNCE_CYCLES/CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  deb_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dout_q, dout_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 s;

  // With EN low the chain recirculates DOUT, so X never enters and no edge appears on re-enable.
  gpio_sync #(
    .Stages  (SYNC_STAGES),
    .ResetVal(RESET_VAL)
  ) u_sync (
    .clk_i(CK),
    .rst_i(RST),
    .sel_i(EN),
    .d_i  (DIN),
    .alt_i(dout_q),
    .q_o  (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!EN) begin
      state_d = StStable;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StStable: begin
          if (s == dout_q) begin
            cnt_d = '0;
          end else if (DEBOUNCE_CYCLES == 1) begin
            dout_d = s;
            rise_d = s;
            fall_d = ~s;
          end else begin
            state_d = StCount;
            cnt_d   = CntOne;
          end
        end
        StCount: begin
          if (s == dout_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            dout_d  = s;
            rise_d  = s;
            fall_d  = ~s;
            state_d = StStable;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StStable;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= StStable;
      cnt_q   <= '0;
      dout_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign DOUT = dout_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign BUSY = (state_q == StCount);

  cnt_no_overflow_a : assert property (@(posedge CK) disable iff (RST) cnt_q <= CntLast)
    else $error("gpio_in_debounce: debounce counter exceeded DEBOUNCE_CYCLES-1");

`ifdef GPIO_DEBOUNCE_STICKY_EN
  logic evt_rise_q, evt_fall_q;

  // Set has priority over a coincident clear.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      evt_rise_q <= 1'b0;
      evt_fall_q <= 1'b0;
    end else begin
      if (rise_q) evt_rise_q <= 1'b1;
      else if (EVT_CLR) evt_rise_q <= 1'b0;
      if (fall_q) evt_fall_q <= 1'b1;
      else if (EVT_CLR) evt_fall_q <= 1'b0;
    end
  end

  assign EVT_RISE = evt_rise_q;
  assign EVT_FALL = evt_fall_q;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: default instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_gpio_in_debounce;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic din0 = 1'b0;
  logic din1 = 1'b0;
  logic dout0, rise0, fall0, busy0;
  logic dout1, rise1, fall1, busy1;
`ifdef GPIO_DEBOUNCE_STICKY_EN
  logic evt_clr = 1'b0;
  logic evt_rise0, evt_fall0, evt_rise1, evt_fall1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_in_debounce #(
    .SYNC_STAGES(SYNC), .CNT_WIDTH(8), .DEBOUNCE_CYCLES(16), .RESET_VAL(1'b0)
  ) dut (
    .CK(clk), .RST(rst), .EN(en), .DIN(din0),
`ifdef GPIO_DEBOUNCE_STICKY_EN
    .EVT_CLR(evt_clr), .EVT_RISE(evt_rise0), .EVT_FALL(evt_fall0),
`endif
    .DOUT(dout0), .RISE(rise0), .FALL(fall0), .BUSY(busy0)
  );

  gpio_in_debounce #(
    .SYNC_STAGES(SYNC), .CNT_WIDTH(4), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)
  ) dut1 (
    .CK(clk), .RST(rst), .EN(en), .DIN(din1),
`ifdef GPIO_DEBOUNCE_STICKY_EN
    .EVT_CLR(evt_clr), .EVT_RISE(evt_rise1), .EVT_FALL(evt_fall1),
`endif
    .DOUT(dout1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
  );

  // Reference: a level is accepted after D consecutive enabled samples that differ from DOUT,
  // where a sample is the first-stage input delayed through SYNC flops.
  logic [SYNC-1:0] m_pipe [2];
  logic            m_dout [2];
  logic            m_rise [2];
  logic            m_fall [2];
  int              m_run  [2];

  function automatic int dcyc(input int i);
    return (i == 0) ? 16 : 1;
  endfunction

  function automatic logic [3:0] exp_vec(input int i);
    return {m_dout[i], m_rise[i], m_fall[i], m_run[i] != 0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pipe[i] = '0;
      m_dout[i] = 1'b0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      m_run[i]  = 0;
    end
  endtask

  task automatic model_step(input int i, input logic en_v, input logic din_v);
    logic s, first;
    s     = m_pipe[i][SYNC-1];
    first = en_v ? din_v : m_dout[i];
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (!en_v || s == m_dout[i]) begin
      m_run[i] = 0;
    end else begin
      m_run[i]++;
      if (m_run[i] == dcyc(i)) begin
        m_dout[i] = s;
        m_rise[i] = s;
        m_fall[i] = ~s;
        m_run[i]  = 0;
      end
    end
    m_pipe[i] = {m_pipe[i][SYNC-2:0], first};
  endtask

  // Advance one edge; inputs are captured before the edge, outputs settle by #1 after.
  task automatic tick();
    logic en_v, d0, d1;
    en_v = en;
    d0   = din0;
    d1   = din1;
    @(posedge clk);
    if (!rst) begin
      model_step(0, en_v, d0);
      model_step(1, en_v, d1);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; din0 = 1'b0; din1 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dout0, rise0, fall0, busy0, dout1, rise1, fall1, busy1} !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got %b expected 00000000",
               {dout0, rise0, fall0, busy0, dout1, rise1, fall1, busy1});
    end
    rst = 1'b0;
    en  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if ({dout0, rise0, fall0, busy0} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: got %b expected 0000", c, {dout0, rise0, fall0, busy0});
      end
    end
  endtask

  task automatic test_clean_edge(input logic lvl);
    int lat, busy_cnt, pulses;
    logic pulse_at;
    lat = -1; busy_cnt = 0; pulses = 0; pulse_at = 1'b0;
    din0 = lvl;
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp_vec(0)) begin
        errors++;
        $display("FAIL clean_edge_model lvl=%b cyc=%0d: got %b expected %b",
                 lvl, c, {dout0, rise0, fall0, busy0}, exp_vec(0));
      end
      if (busy0) busy_cnt++;
      if (lvl ? rise0 : fall0) pulses++;
      if (dout0 == lvl && lat < 0) begin
        lat = c;
        pulse_at = lvl ? rise0 : fall0;
      end
    end
    checks++;
    if (lat != 18 || pulse_at !== 1'b1 || pulses != 1 || busy_cnt != 15) begin
      errors++;
      $display("FAIL clean_edge lvl=%b: got latency=%0d pulse=%b pulses=%0d busy=%0d expected 18 1 1 15",
               lvl, lat, pulse_at, pulses, busy_cnt);
    end
  endtask

  task automatic test_bounce();
    int lat, pulses;
    lat = -1; pulses = 0;
    for (int c = 0; c < 53; c++) begin
      if (c == 0) din0 = 1'b1;
      if (c == 10) din0 = 1'b0;
      if (c == 13) din0 = 1'b1;
      tick();
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp_vec(0)) begin
        errors++;
        $display("FAIL bounce_model cyc=%0d: got %b expected %b",
                 c, {dout0, rise0, fall0, busy0}, exp_vec(0));
      end
      if (rise0 || fall0) pulses++;
      if (dout0 && lat < 0) lat = c - 12;
    end
    checks++;
    if (lat != 18 || pulses != 1) begin
      errors++;
      $display("FAIL bounce: got latency=%0d pulses=%0d expected 18 1", lat, pulses);
    end
  endtask

  task automatic test_rst_mid_count();
    din0 = 1'b0;
    repeat (8) tick();
    checks++;
    if (busy0 !== 1'b1 || dout0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_precond: got busy=%b dout=%b expected 1 1", busy0, dout0);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({dout0, rise0, fall0, busy0, dout1, rise1, fall1, busy1} !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_async: got %b expected 00000000",
               {dout0, rise0, fall0, busy0, dout1, rise1, fall1, busy1});
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if ({dout0, rise0, fall0, busy0} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_after: got %b expected 0000", {dout0, rise0, fall0, busy0});
    end
  endtask

  task automatic test_en_drop();
    int lat;
    lat = -1;
    din0 = 1'b1;
    repeat (10) tick();
    checks++;
    if (busy0 !== 1'b1 || m_run[0] != 8) begin
      errors++;
      $display("FAIL en_drop_precond: got busy=%b run=%0d expected 1 8", busy0, m_run[0]);
    end
    en = 1'b0;
    din0 = 1'bx;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ($isunknown({dout0, rise0, fall0, busy0}) || {dout0, rise0, fall0, busy0} !== 4'b0000) begin
        errors++;
        $display("FAIL en_drop_hold cyc=%0d: got %b expected 0000", c, {dout0, rise0, fall0, busy0});
      end
    end
    en = 1'b1;
    din0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if ({dout0, rise0, fall0, busy0} !== exp_vec(0)) begin
        errors++;
        $display("FAIL en_drop_model cyc=%0d: got %b expected %b",
                 c, {dout0, rise0, fall0, busy0}, exp_vec(0));
      end
      if (dout0 && lat < 0) lat = c;
    end
    checks++;
    if (lat != 18) begin
      errors++;
      $display("FAIL en_drop_reassert: got latency=%0d expected 18", lat);
    end
  endtask

  task automatic test_d1();
    logic hist [0:63];
    int last, pulses;
    last = -1; pulses = 0;
    en = 1'b1;
    din1 = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      if ((c - 1) % 4 == 0) din1 = ~din1;
      hist[c] = din1;
      tick();
      checks++;
      if ({dout1, rise1, fall1, busy1} !== exp_vec(1)) begin
        errors++;
        $display("FAIL d1_model cyc=%0d: got %b expected %b",
                 c, {dout1, rise1, fall1, busy1}, exp_vec(1));
      end
      if (c > 2) begin
        checks++;
        if (dout1 !== hist[c-2]) begin
          errors++;
          $display("FAIL d1_track cyc=%0d: got %b expected %b", c, dout1, hist[c-2]);
        end
      end
      if (rise1 || fall1) begin
        pulses++;
        checks++;
        if ((rise1 && fall1) || (rise1 && last == 1) || (fall1 && last == 0)) begin
          errors++;
          $display("FAIL d1_alternate cyc=%0d: got rise=%b fall=%b last=%0d", c, rise1, fall1, last);
        end
        last = rise1 ? 1 : 0;
      end
    end
    checks++;
    if (pulses != 12) begin
      errors++;
      $display("FAIL d1_pulse_count: got %0d expected 12", pulses);
    end
  endtask

  task automatic test_random();
    int seg_len, p0, p1;
    seg_len = 0; p0 = 2; p1 = 2;
    for (int c = 0; c < 1200; c++) begin
      if (seg_len == 0) begin
        seg_len = $urandom_range(10, 60);
        p0 = $urandom_range(1, 3) * $urandom_range(1, 15);
        p1 = $urandom_range(1, 6);
      end
      seg_len--;
      if ($urandom_range(0, p0 * 4) == 0) din0 = ~din0;
      if ($urandom_range(0, p1) == 0) din1 = ~din1;
      if (en) en = ($urandom_range(0, 99) != 0);
      else en = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({dout0, rise0, fall0, busy0, dout1, rise1, fall1, busy1} !== {exp_vec(0), exp_vec(1)}) begin
        errors++;
        $display("FAIL random cyc=%0d: got %b expected %b", c,
                 {dout0, rise0, fall0, busy0, dout1, rise1, fall1, busy1}, {exp_vec(0), exp_vec(1)});
      end
    end
  endtask

`ifdef GPIO_DEBOUNCE_STICKY_EN
  task automatic test_sticky();
    int c;
    en = 1'b1;
    din0 = 1'b1;
    repeat (25) tick();
    din0 = 1'b0;
    evt_clr = 1'b1;
    c = 0;
    while (!fall0 && c < 40) begin
      tick();
      c++;
    end
    checks++;
    if (fall0 !== 1'b1) begin
      errors++;
      $display("FAIL sticky_fall_wait: got fall=%b expected 1", fall0);
    end
    tick();
    checks++;
    if (evt_fall0 !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b expected 1", evt_fall0);
    end
    tick();
    checks++;
    if (evt_fall0 !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b expected 0", evt_fall0);
    end
    evt_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_edge(1'b1);
    test_clean_edge(1'b0);
    test_bounce();
    test_rst_mid_count();
    test_en_drop();
    test_d1();
    test_random();
`ifdef GPIO_DEBOUNCE_STICKY_EN
    test_sticky();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
